x2050tshift: RTL and testbench
==============================

Name: x2050tshift

Overview:
- Parametrised successor to the 2050 T/F/Q register path.
- Holds the T working register plus the F digit register and Q bit register.
- Runs multi-position bit and digit shifts as an iterative, ROS-advance-gated sequence of one step per advance.
- Sits between the adder output latch and the T/F/Q consumers; replaces repeated single-step microorders for long shifts.

Parameters:
- W, 32, T register width (bits; index W-1 is IBM bit 0 / MSB).
- FW, 4, F register width (digit size); W must be a multiple of FW.
- CW, $clog2(W)+1, shift-count width (must hold values 0..W).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_ros_advance  in  1  step/commit enable; all state changes are gated by it
- i_load  in  1  load T from i_t0 (IDLE only)
- i_t0  in  W  adder output latch value
- i_start  in  1  begin shift sequence (IDLE only)
- i_op  in  3  shift operation code
- i_count  in  CW  number of steps, 0..W
- o_busy  out  1  sequence in progress (RUN)
- o_done  out  1  one-cycle completion pulse
- o_t_reg  out  W  T register
- o_f_reg  out  FW  F register
- o_q_reg  out  1  Q register

Behaviour:
- Reset (synchronous, any state, including mid-sequence):
  - o_t_reg, o_f_reg, o_q_reg = 0; o_busy = 0; o_done = 0; state = IDLE; latched op and count = 0.
- States:
  - IDLE -> RUN: i_start & i_ros_advance & i_count != 0.
  - IDLE -> DONE: i_start & i_ros_advance & i_count == 0.
  - RUN -> DONE: the advance cycle that performs the last step.
  - DONE -> IDLE: unconditionally on the next clock.
- IDLE:
  - i_load & i_ros_advance: T <= i_t0; F and Q unchanged.
  - Load and start in the same cycle: both accepted. T takes i_t0; the first step executes on the next advance.
- RUN:
  - Each cycle with i_ros_advance=1 performs one step and decrements the counter.
  - i_ros_advance=0 holds all state; the sequence stalls.
  - o_busy = 1 throughout RUN.
- DONE: o_done = 1 for exactly one clock, independent of i_ros_advance. Latency from start to o_done is count+1 advances (minimum 1 clock when count = 0).
- i_start or i_load in RUN or DONE: ignored; no queuing.
- Ops, one step each ({} concatenation, MSB first):
  - 0 SRL: T <= {0, T[W-1:1]}; Q <= T[0].
  - 1 SRA: T <= {T[W-1], T[W-1:1]}; Q <= T[0].
  - 2 SLL: T <= {T[W-2:0], 0}; Q <= T[W-1].
  - 3 SLQ: T <= {T[W-2:0], Q}; Q <= T[W-1] (rotate through Q).
  - 4 SRD: F <= T[FW-1:0]; T <= {FW'b0, T[W-1:FW]}.
  - 5 SLD: F <= T[W-1:W-FW]; T <= {T[W-FW-1:0], F} (old F enters).
  - 6 ROL: T <= {T[W-2:0], T[W-1]}; Q unchanged.
  - 7 NOP: step changes nothing; count still consumed.
- Count and op are latched at start; later input changes do not affect the running sequence.
- i_count > W is saturated to W at latch time.

Optional Feature:
- Macro: X2050_TSHIFT_STICKY_EN.
- Enabled:
  - Extra output o_sticky (1 bit).
  - Cleared when a sequence is accepted.
  - Thereafter ORed with every bit (ops 0,1) or digit (op 4) discarded from the right end during RUN.
  - Holds its value until the next start or reset; reset value 0.
- Disabled: port absent, no logic.

Decomposition:
- Shared package x2050_pkg: op-code localparams (TSH_SRL..TSH_NOP) and the state encoding enum (IDLE, RUN, DONE).
- One sub-module x2050tshift_step: purely combinational single-step datapath (op, T, F, Q in -> next T/F/Q, discarded bits out).
- The top level holds the sequencer, counter and registers.

Test Plan:
- Load 0x8000_0001, SRL count 4, advance held high:
  - o_busy 4 cycles, then o_done 1 cycle.
  - T = 0x0800_0000, Q = 0; sticky = 1 if enabled.
- Load 0x8000_0000, SRA count 3 -> T = 0xF000_0000, Q = 0.
- F = 0xA, T = 0x1234_5678, SLD count 1 -> T = 0x2345_678A, F = 0x1.
- SLL count 2 on 0xC000_0000 with i_ros_advance toggling 1,0,1:
  - Result lands only after 2 advances: T = 0, Q = 1.
  - o_done one cycle later; state held while advance = 0.
- i_start with count 0 -> o_done next clock, T/F/Q unchanged, o_busy never high.
- Reset asserted mid-RUN of a SRD count 8:
  - Next clock all outputs 0, state IDLE.
  - A new i_start is then accepted normally.

Source files
------------

// File: rtl/x2050_pkg.sv
// rtl/x2050_pkg.sv - shared op codes and sequencer state encoding for the T/F/Q shifter
package x2050_pkg;

   localparam logic [2:0] TSH_SRL = 3'd0;
   localparam logic [2:0] TSH_SRA = 3'd1;
   localparam logic [2:0] TSH_SLL = 3'd2;
   localparam logic [2:0] TSH_SLQ = 3'd3;
   localparam logic [2:0] TSH_SRD = 3'd4;
   localparam logic [2:0] TSH_SLD = 3'd5;
   localparam logic [2:0] TSH_ROL = 3'd6;
   localparam logic [2:0] TSH_NOP = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } tsh_state_t;

endpackage

// File: rtl/x2050tshift_step.sv
// rtl/x2050tshift_step.sv - combinational single-step T/F/Q shift datapath
// o_discard exists only when X2050_TSHIFT_STICKY_EN is defined.
module x2050tshift_step
   import x2050_pkg::*;
#(
   parameter int W  = 32,
   parameter int FW = 4
) (
   input  logic [2:0]    i_op,
   input  logic [W-1:0]  i_t,
   input  logic [FW-1:0] i_f,
   input  logic          i_q,
   output logic [W-1:0]  o_t,
   output logic [FW-1:0] o_f,
   output logic          o_q
`ifdef X2050_TSHIFT_STICKY_EN
   ,
   output logic          o_discard
`endif
);

   always_comb begin
      o_t = i_t;
      o_f = i_f;
      o_q = i_q;
      case (i_op)
         TSH_SRL: begin
            o_t = {1'b0, i_t[W-1:1]};
            o_q = i_t[0];
         end
         TSH_SRA: begin
            o_t = {i_t[W-1], i_t[W-1:1]};
            o_q = i_t[0];
         end
         TSH_SLL: begin
            o_t = {i_t[W-2:0], 1'b0};
            o_q = i_t[W-1];
         end
         TSH_SLQ: begin
            o_t = {i_t[W-2:0], i_q};
            o_q = i_t[W-1];
         end
         TSH_SRD: begin
            o_f = i_t[FW-1:0];
            o_t = {{FW{1'b0}}, i_t[W-1:FW]};
         end
         TSH_SLD: begin
            // old F digit is shifted into the low end of T
            o_f = i_t[W-1:W-FW];
            o_t = {i_t[W-FW-1:0], i_f};
         end
         TSH_ROL: o_t = {i_t[W-2:0], i_t[W-1]};
         default: ;
      endcase
   end

`ifdef X2050_TSHIFT_STICKY_EN
   assign o_discard = ((i_op == TSH_SRL) || (i_op == TSH_SRA)) ? i_t[0] :
                      (i_op == TSH_SRD) ? (|i_t[FW-1:0]) : 1'b0;
`endif

endmodule

// File: rtl/x2050tshift.sv
// rtl/x2050tshift.sv - T/F/Q register path with ROS-advance-gated multi-step shift sequencer
// Optional sticky output o_sticky is built when X2050_TSHIFT_STICKY_EN is defined.
module x2050tshift
   import x2050_pkg::*;
#(
   parameter int W  = 32,
   parameter int FW = 4,
   parameter int CW = $clog2(W) + 1
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_ros_advance,
   input  logic          i_load,
   input  logic [W-1:0]  i_t0,
   input  logic          i_start,
   input  logic [2:0]    i_op,
   input  logic [CW-1:0] i_count,
   output logic          o_busy,
   output logic          o_done,
   output logic [W-1:0]  o_t_reg,
   output logic [FW-1:0] o_f_reg,
   output logic          o_q_reg
`ifdef X2050_TSHIFT_STICKY_EN
   ,
   output logic          o_sticky
`endif
);

   tsh_state_t    r_state;
   tsh_state_t    w_state_nxt;
   logic [W-1:0]  r_t;
   logic [FW-1:0] r_f;
   logic          r_q;
   logic [2:0]    r_op;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_count_sat;
   logic [W-1:0]  w_t_nxt;
   logic [FW-1:0] w_f_nxt;
   logic          w_q_nxt;
   logic          w_accept;

   assign w_count_sat = (i_count > CW'(W)) ? CW'(W) : i_count;
   assign w_accept    = (r_state == IDLE) && i_start && i_ros_advance;

`ifdef X2050_TSHIFT_STICKY_EN
   logic r_sticky;
   logic w_discard;
`endif

   x2050tshift_step #(.W(W), .FW(FW)) u_step (
      .i_op      (r_op),
      .i_t       (r_t),
      .i_f       (r_f),
      .i_q       (r_q),
      .o_t       (w_t_nxt),
      .o_f       (w_f_nxt),
      .o_q       (w_q_nxt)
`ifdef X2050_TSHIFT_STICKY_EN
      ,
      .o_discard (w_discard)
`endif
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (w_accept) w_state_nxt = (i_count == '0) ? DONE : RUN;
         RUN:  if (i_ros_advance && (r_cnt == CW'(1))) w_state_nxt = DONE;
         DONE: w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_t   <= '0;
         r_f   <= '0;
         r_q   <= 1'b0;
         r_op  <= '0;
         r_cnt <= '0;
      end else if (r_state == IDLE) begin
         if (i_load && i_ros_advance) r_t <= i_t0;
         if (w_accept) begin
            r_op  <= i_op;
            r_cnt <= w_count_sat;
         end
      end else if ((r_state == RUN) && i_ros_advance) begin
         r_t   <= w_t_nxt;
         r_f   <= w_f_nxt;
         r_q   <= w_q_nxt;
         r_cnt <= r_cnt - CW'(1);
      end
   end

`ifdef X2050_TSHIFT_STICKY_EN
   always_ff @(posedge i_clk) begin
      if (i_reset)                                    r_sticky <= 1'b0;
      else if (w_accept)                              r_sticky <= 1'b0;
      else if ((r_state == RUN) && i_ros_advance)     r_sticky <= r_sticky | w_discard;
   end
   assign o_sticky = r_sticky;
`endif

   assign o_busy  = (r_state == RUN);
   assign o_done  = (r_state == DONE);
   assign o_t_reg = r_t;
   assign o_f_reg = r_f;
   assign o_q_reg = r_q;

endmodule

// File: tb/tb_x2050tshift.sv
// tb/tb_x2050tshift.sv - directed and randomized bench for x2050tshift against an arithmetic reference model
module tb_x2050tshift;

   logic        clk = 1'b0;
   logic        reset;
   logic        ros_advance;
   logic        load;
   logic [31:0] t0;
   logic        start;
   logic [2:0]  op;
   logic [5:0]  count;
   logic        busy;
   logic        done;
   logic [31:0] t_reg;
   logic [3:0]  f_reg;
   logic        q_reg;
`ifdef X2050_TSHIFT_STICKY_EN
   logic        sticky;
`endif

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] mt = '0;
   logic [3:0]  mf = '0;
   logic        mq = 1'b0;
   logic        ms = 1'b0;

   x2050tshift dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_ros_advance (ros_advance),
      .i_load        (load),
      .i_t0          (t0),
      .i_start       (start),
      .i_op          (op),
      .i_count       (count),
      .o_busy        (busy),
      .o_done        (done),
      .o_t_reg       (t_reg),
      .o_f_reg       (f_reg),
      .o_q_reg       (q_reg)
`ifdef X2050_TSHIFT_STICKY_EN
      ,
      .o_sticky      (sticky)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // reference: one shift step expressed as integer arithmetic on the model registers
   task automatic model_step(input logic [2:0] o);
      logic [3:0]  nf;
      logic        nq;
      case (o)
         3'd0: begin ms |= mt[0]; mq = mt[0]; mt = mt >> 1; end
         3'd1: begin ms |= mt[0]; mq = mt[0]; mt = 32'($signed(mt) >>> 1); end
         3'd2: begin mq = mt[31]; mt = mt << 1; end
         3'd3: begin nq = mt[31]; mt = (mt << 1) | {31'd0, mq}; mq = nq; end
         3'd4: begin ms |= ((mt % 16) != 0); mf = 4'(mt % 16); mt = mt / 16; end
         3'd5: begin nf = 4'(mt / 32'h1000_0000); mt = (mt * 16) | {28'd0, mf}; mf = nf; end
         3'd6: mt = (mt << 1) | (mt >> 31);
         default: ;
      endcase
   endtask

   task automatic do_load(input logic [31:0] v);
      load = 1'b1; t0 = v; ros_advance = 1'b1;
      tick();
      load = 1'b0;
      mt = v;
   endtask

   // mode 0: advance always high, 1: random stalls, 2: alternate 1,0,1,...
   task automatic do_seq(input logic [2:0] o, input int cnt, input bit ld,
                         input logic [31:0] ldv, input int mode);
      int  rem;
      int  k;
      logic adv;
      start = 1'b1; load = ld; t0 = ldv; op = o; count = 6'(cnt); ros_advance = 1'b1;
      if (ld) mt = ldv;
      ms  = 1'b0;
      rem = (cnt > 32) ? 32 : cnt;
      tick();
      start = 1'b0; load = 1'b0; op = 3'($urandom); count = 6'($urandom); t0 = $urandom;
      k = 0;
      while (rem > 0 && k < 1000) begin
         chk("busy_run", {31'd0, busy}, 32'd1);
         chk("done_run", {31'd0, done}, 32'd0);
         chk("t_run", t_reg, mt);
         adv = (mode == 0) ? 1'b1 : (mode == 2) ? ((k % 2) == 0) : ($urandom_range(0, 3) != 0);
         ros_advance = adv;
         start = 1'($urandom_range(0, 1));
         load  = 1'($urandom_range(0, 1));
         if (adv) begin
            model_step(o);
            rem--;
         end
         tick();
         k++;
      end
      if (rem > 0) chk("seq_bound", 32'(rem), 32'd0);
      start = 1'b0; load = 1'b0; ros_advance = 1'($urandom_range(0, 1));
      chk("done_pulse", {31'd0, done}, 32'd1);
      chk("busy_done", {31'd0, busy}, 32'd0);
      chk("t_final", t_reg, mt);
      chk("f_final", {28'd0, f_reg}, {28'd0, mf});
      chk("q_final", {31'd0, q_reg}, {31'd0, mq});
`ifdef X2050_TSHIFT_STICKY_EN
      chk("sticky", {31'd0, sticky}, {31'd0, ms});
`endif
      tick();
      chk("done_clear", {31'd0, done}, 32'd0);
      chk("busy_idle", {31'd0, busy}, 32'd0);
      chk("t_idle", t_reg, mt);
   endtask

   initial begin
      reset = 1'b1; ros_advance = 1'b0; load = 1'b0; t0 = '0;
      start = 1'b0; op = '0; count = '0;
      tick();
      tick();
      chk("rst_t", t_reg, 32'd0);
      chk("rst_f", {28'd0, f_reg}, 32'd0);
      chk("rst_q", {31'd0, q_reg}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      reset = 1'b0;

      // load without advance is ignored
      load = 1'b1; t0 = 32'h5555_5555; ros_advance = 1'b0;
      tick();
      load = 1'b0;
      chk("load_noadv", t_reg, 32'd0);

      do_load(32'h8000_0001);
      chk("load_t", t_reg, 32'h8000_0001);
      do_seq(3'd0, 4, 1'b0, 32'd0, 0);
      chk("srl_t", t_reg, 32'h0800_0000);
      chk("srl_q", {31'd0, q_reg}, 32'd0);

      do_seq(3'd1, 3, 1'b1, 32'h8000_0000, 0);
      chk("sra_t", t_reg, 32'hF000_0000);
      chk("sra_q", {31'd0, q_reg}, 32'd0);

      do_seq(3'd4, 1, 1'b1, 32'h0000_000A, 0);
      chk("srd_f", {28'd0, f_reg}, 32'hA);
      do_seq(3'd5, 1, 1'b1, 32'h1234_5678, 0);
      chk("sld_t", t_reg, 32'h2345_678A);
      chk("sld_f", {28'd0, f_reg}, 32'h1);

      do_seq(3'd2, 2, 1'b1, 32'hC000_0000, 2);
      chk("sll_t", t_reg, 32'd0);
      chk("sll_q", {31'd0, q_reg}, 32'd1);

      do_seq(3'd6, 0, 1'b0, 32'd0, 0);
      chk("cnt0_t", t_reg, 32'd0);

      do_seq(3'd6, 40, 1'b1, 32'h1357_9BDF, 1);
      chk("sat_rol_t", t_reg, 32'h1357_9BDF);

      do_load(32'hDEAD_BEEF);
      start = 1'b1; op = 3'd4; count = 6'd8; ros_advance = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      ros_advance = 1'b0;
      chk("midrst_t", t_reg, 32'd0);
      chk("midrst_f", {28'd0, f_reg}, 32'd0);
      chk("midrst_q", {31'd0, q_reg}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
`ifdef X2050_TSHIFT_STICKY_EN
      chk("midrst_sticky", {31'd0, sticky}, 32'd0);
`endif
      mt = '0; mf = '0; mq = 1'b0;
      do_seq(3'd0, 5, 1'b1, 32'hFFFF_0003, 1);

      for (int i = 0; i < 60; i++) begin
         do_seq(3'($urandom_range(0, 7)), int'($urandom_range(0, 40)),
                1'($urandom_range(0, 1)), $urandom, 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
